// File: rtl/conv1d_cmd_sequencer.sv
// Drives one conv1d CFU from a local byte memory: configures it, streams the filter/input bytes,
// starts the kernel, polls its status and hands the accumulator back to the host.
module conv1d_cmd_sequencer #(
    parameter int BYTE_SIZE          = 8,
    parameter int INT32_SIZE         = 32,
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int MEM_AW             = 12,
    parameter int POLL_TIMEOUT       = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [INT32_SIZE-1:0] depth,
    input  logic [INT32_SIZE-1:0] in_offset,
    input  logic [INT32_SIZE-1:0] start_x,
    input  logic                  load_filter,
    input  logic [MEM_AW-1:0]     filt_base,
    input  logic [MEM_AW-1:0]     inp_base,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [BYTE_SIZE-1:0]  mem_rdata,
    output logic [6:0]            cfu_cmd,
    output logic [INT32_SIZE-1:0] cfu_inp0,
    output logic [INT32_SIZE-1:0] cfu_inp1,
    input  logic [INT32_SIZE-1:0] cfu_ret,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [INT32_SIZE-1:0] res_data,
    output logic                  res_err
);

    localparam logic [6:0] CMD_NOP    = 7'd127;
    localparam logic [6:0] CMD_DEPTH  = 7'd5;
    localparam logic [6:0] CMD_OFFSET = 7'd3;
    localparam logic [6:0] CMD_FILT   = 7'd2;
    localparam logic [6:0] CMD_INP    = 7'd1;
    localparam logic [6:0] CMD_SETX   = 7'd8;
    localparam logic [6:0] CMD_START  = 7'd6;
    localparam logic [6:0] CMD_STATUS = 7'd9;
    localparam logic [6:0] CMD_ACC    = 7'd7;

    localparam int PCW = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_DEPTH,
        S_CFG_OFF,
        S_LOAD_FILT,
        S_LOAD_INP,
        S_SET_X,
        S_START,
        S_POLL,
        S_POLL_WAIT,
        S_READ_ACC,
        S_READ_WAIT,
        S_RESULT
    } state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             cnt_reg, cnt_next;
    logic [PCW-1:0]          poll_reg, poll_next;
    logic [INT32_SIZE-1:0]   res_data_reg, res_data_next;
    logic                    res_err_reg, res_err_next;
    logic                    latch_params;

    logic [INT32_SIZE-1:0]   depth_reg;
    logic [INT32_SIZE-1:0]   offset_reg;
    logic [INT32_SIZE-1:0]   start_x_reg;
    logic                    load_filter_reg;
    logic [MEM_AW-1:0]       filt_base_reg;
    logic [MEM_AW-1:0]       inp_base_reg;
    logic [15:0]             n_reg;

    logic                    depth_ok;
    logic [15:0]             n_calc;
    logic [INT32_SIZE-1:0]   rdata_sext;
    logic [MEM_AW-1:0]       load_base;
    logic [6:0]              load_cmd;

    assign depth_ok   = (depth != '0) && (depth <= INT32_SIZE'(MAX_INPUT_CHANNELS));
    assign n_calc     = 16'(32'(KERNEL_LENGTH) * 32'(depth));
    assign rdata_sext = {{(INT32_SIZE-BYTE_SIZE){mem_rdata[BYTE_SIZE-1]}}, mem_rdata};

    assign busy      = (state_reg != S_IDLE);
    assign res_valid = (state_reg == S_RESULT);
    assign res_data  = res_data_reg;
    assign res_err   = res_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            poll_reg        <= '0;
            res_data_reg    <= '0;
            res_err_reg     <= 1'b0;
            depth_reg       <= '0;
            offset_reg      <= '0;
            start_x_reg     <= '0;
            load_filter_reg <= 1'b0;
            filt_base_reg   <= '0;
            inp_base_reg    <= '0;
            n_reg           <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            poll_reg     <= poll_next;
            res_data_reg <= res_data_next;
            res_err_reg  <= res_err_next;
            if (latch_params) begin
                depth_reg       <= depth;
                offset_reg      <= in_offset;
                start_x_reg     <= start_x;
                load_filter_reg <= load_filter;
                filt_base_reg   <= filt_base;
                inp_base_reg    <= inp_base;
                n_reg           <= n_calc;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        poll_next     = poll_reg;
        res_data_next = res_data_reg;
        res_err_next  = res_err_reg;
        latch_params  = 1'b0;
        cfu_cmd       = CMD_NOP;
        cfu_inp0      = '0;
        cfu_inp1      = '0;
        mem_rd_en     = 1'b0;
        mem_addr      = '0;
        load_base     = (state_reg == S_LOAD_FILT) ? filt_base_reg : inp_base_reg;
        load_cmd      = (state_reg == S_LOAD_FILT) ? CMD_FILT : CMD_INP;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (!depth_ok) begin
                        res_data_next = '0;
                        res_err_next  = 1'b1;
                        state_next    = S_RESULT;
                    end else begin
                        latch_params = 1'b1;
                        cnt_next     = '0;
                        poll_next    = '0;
                        state_next   = S_CFG_DEPTH;
                    end
                end
            end
            S_CFG_DEPTH: begin
                cfu_cmd    = CMD_DEPTH;
                cfu_inp1   = depth_reg;
                state_next = S_CFG_OFF;
            end
            S_CFG_OFF: begin
                cfu_cmd    = CMD_OFFSET;
                cfu_inp1   = offset_reg;
                cnt_next   = '0;
                state_next = load_filter_reg ? S_LOAD_FILT : S_LOAD_INP;
            end
            // Read of byte k overlaps the write of byte k-1, so a load takes N+1 cycles.
            S_LOAD_FILT, S_LOAD_INP: begin
                if (cnt_reg < n_reg) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = load_base + MEM_AW'(cnt_reg);
                end
                if (cnt_reg != 16'd0) begin
                    cfu_cmd  = load_cmd;
                    cfu_inp0 = INT32_SIZE'(cnt_reg - 16'd1);
                    cfu_inp1 = rdata_sext;
                end
                if (cnt_reg == n_reg) begin
                    cnt_next   = '0;
                    state_next = (state_reg == S_LOAD_FILT) ? S_LOAD_INP : S_SET_X;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_SET_X: begin
                cfu_cmd    = CMD_SETX;
                cfu_inp1   = start_x_reg;
                state_next = S_START;
            end
            S_START: begin
                cfu_cmd    = CMD_START;
                state_next = S_POLL;
            end
            S_POLL: begin
                cfu_cmd    = CMD_STATUS;
                state_next = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (cfu_ret[0]) begin
                    state_next = S_READ_ACC;
                end else if (poll_reg == PCW'(POLL_TIMEOUT - 1)) begin
                    res_data_next = '0;
                    res_err_next  = 1'b1;
                    state_next    = S_RESULT;
                end else begin
                    poll_next  = poll_reg + 1'b1;
                    state_next = S_POLL;
                end
            end
            S_READ_ACC: begin
                cfu_cmd    = CMD_ACC;
                state_next = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                res_data_next = cfu_ret;
                res_err_next  = 1'b0;
                state_next    = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Directed bench for conv1d_cmd_sequencer: byte-memory and CFU models, full command-trace checks.
module tb_conv1d_cmd_sequencer;

    localparam int          PT  = 16;
    localparam logic [6:0]  NOP = 7'd127;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] depth = '0, in_offset = '0, start_x = '0;
    logic        load_filter = 1'b0;
    logic [11:0] filt_base = '0, inp_base = '0;
    logic        busy, mem_rd_en;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [6:0]  cfu_cmd;
    logic [31:0] cfu_inp0, cfu_inp1, cfu_ret;
    logic        res_valid, res_err;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;

    logic [7:0]  mem [0:4095];
    int          polls_seen;
    int          done_at = 1;
    logic [31:0] acc_val = '0;
    logic        model_clear = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [70:0] tr_q[$];
    logic [70:0] exp_q[$];
    int busy_low;
    int wait_cyc;

    always #5 clk = ~clk;

    conv1d_cmd_sequencer #(.POLL_TIMEOUT(PT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .depth(depth), .in_offset(in_offset),
        .start_x(start_x), .load_filter(load_filter), .filt_base(filt_base), .inp_base(inp_base),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0), .cfu_inp1(cfu_inp1), .cfu_ret(cfu_ret),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // CFU model: status bit0 rises on poll number done_at (0 = never); bit1 is noise.
    always @(posedge clk) begin
        if (model_clear) polls_seen <= 0;
        case (cfu_cmd)
            7'd9: begin
                if (!model_clear) polls_seen <= polls_seen + 1;
                cfu_ret <= (done_at != 0 && polls_seen + 1 >= done_at) ? 32'h1 : 32'h2;
            end
            7'd7:    cfu_ret <= acc_val;
            default: cfu_ret <= 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    task automatic build_exp(input logic [31:0] d, input logic [31:0] off, input logic [31:0] sx,
                             input logic lf, input logic [11:0] fb, input logic [11:0] ib,
                             input int npoll, input logic ok);
        logic [11:0] a;
        exp_q.delete();
        exp_q.push_back({7'd5, 32'd0, d});
        exp_q.push_back({7'd3, 32'd0, off});
        if (lf) begin
            exp_q.push_back({NOP, 64'd0});
            for (int k = 0; k < 8 * int'(d); k++) begin
                a = fb + 12'(k);
                exp_q.push_back({7'd2, 32'(k), sx8(mem[a])});
            end
        end
        exp_q.push_back({NOP, 64'd0});
        for (int k = 0; k < 8 * int'(d); k++) begin
            a = ib + 12'(k);
            exp_q.push_back({7'd1, 32'(k), sx8(mem[a])});
        end
        exp_q.push_back({7'd8, 32'd0, sx});
        exp_q.push_back({7'd6, 64'd0});
        for (int p = 0; p < npoll; p++) begin
            exp_q.push_back({7'd9, 64'd0});
            exp_q.push_back({NOP, 64'd0});
        end
        if (ok) begin
            exp_q.push_back({7'd7, 64'd0});
            exp_q.push_back({NOP, 64'd0});
        end
    endtask

    task automatic launch(input logic [31:0] d, input logic [31:0] off, input logic [31:0] sx,
                          input logic lf, input logic [11:0] fb, input logic [11:0] ib);
        @(posedge clk); #1;
        depth = d; in_offset = off; start_x = sx; load_filter = lf;
        filt_base = fb; inp_base = ib; start = 1'b1; model_clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; model_clear = 1'b0;
    endtask

    // Records every cycle's command until res_valid; returns at the negedge where it is seen.
    task automatic wait_result(input string tag);
        tr_q.delete();
        busy_low = 0;
        wait_cyc = 0;
        while (wait_cyc < 5000) begin
            @(negedge clk);
            wait_cyc++;
            if (res_valid) break;
            tr_q.push_back({cfu_cmd, cfu_inp0, cfu_inp1});
            if (!busy) busy_low++;
        end
        check({tag, "_res_valid"}, res_valid, 1'b1);
    endtask

    task automatic compare_trace(input string tag);
        int n;
        check({tag, "_len"}, tr_q.size(), exp_q.size());
        n = (tr_q.size() < exp_q.size()) ? tr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cmd%0d", tag, i), tr_q[i], exp_q[i]);
        end
        check({tag, "_busy_low"}, busy_low, 0);
    endtask

    function automatic int count_cmd(input logic [6:0] c);
        int n = 0;
        foreach (tr_q[i]) if (tr_q[i][70:64] == c) n++;
        return n;
    endfunction

    task automatic accept(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 1'b0);
        check({tag, "_busy_drop"}, busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

        // Reset values
        #2;
        check("rst_cmd", cfu_cmd, NOP);
        check("rst_inp0", cfu_inp0, 32'd0);
        check("rst_inp1", cfu_inp1, 32'd0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_addr, 12'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data", res_data, 32'd0);
        check("rst_err", res_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: depth 2, filter reload, sign-extended bytes, input address wraps past 0xFFF
        done_at = 1; acc_val = 32'h1234_5678;
        launch(32'd2, 32'd128, 32'd0, 1'b1, 12'h0F8, 12'hFF8);
        wait_result("t1");
        build_exp(32'd2, 32'd128, 32'd0, 1'b1, 12'h0F8, 12'hFF8, 1, 1'b1);
        compare_trace("t1");
        check("t1_data", res_data, 32'h1234_5678);
        check("t1_err", res_err, 1'b0);
        accept("t1");

        // 2: same run without filter reload
        acc_val = 32'h0000_0ABC;
        launch(32'd2, 32'd128, 32'd0, 1'b0, 12'h0F8, 12'hFF8);
        wait_result("t2");
        build_exp(32'd2, 32'd128, 32'd0, 1'b0, 12'h0F8, 12'hFF8, 1, 1'b1);
        compare_trace("t2");
        check("t2_cmd2_count", count_cmd(7'd2), 0);
        check("t2_cmd1_count", count_cmd(7'd1), 16);
        check("t2_data", res_data, 32'h0000_0ABC);
        accept("t2");

        // 3: done on the 5th poll, negative offset
        done_at = 5; acc_val = 32'hFFFF_FF00;
        launch(32'd1, 32'hFFFF_FFFB, 32'd5, 1'b1, 12'h010, 12'h080);
        wait_result("t3");
        build_exp(32'd1, 32'hFFFF_FFFB, 32'd5, 1'b1, 12'h010, 12'h080, 5, 1'b1);
        compare_trace("t3");
        check("t3_polls", count_cmd(7'd9), 5);
        check("t3_data", res_data, 32'hFFFF_FF00);
        check("t3_err", res_err, 1'b0);
        accept("t3");

        // 4: illegal depths
        launch(32'd0, 32'd0, 32'd0, 1'b1, 12'h0, 12'h0);
        wait_result("t4a");
        check("t4a_latency", wait_cyc <= 2, 1'b1);
        check("t4a_trace_len", tr_q.size(), 0);
        check("t4a_cmd", cfu_cmd, NOP);
        check("t4a_rd_en", mem_rd_en, 1'b0);
        check("t4a_err", res_err, 1'b1);
        check("t4a_data", res_data, 32'd0);
        accept("t4a");
        launch(32'd129, 32'd0, 32'd0, 1'b1, 12'h0, 12'h0);
        wait_result("t4b");
        check("t4b_latency", wait_cyc <= 2, 1'b1);
        check("t4b_trace_len", tr_q.size(), 0);
        check("t4b_cmd", cfu_cmd, NOP);
        check("t4b_err", res_err, 1'b1);
        check("t4b_data", res_data, 32'd0);
        accept("t4b");

        // 5: status never set -> PT polls then error
        done_at = 0; acc_val = 32'h5555_AAAA;
        launch(32'd1, 32'd7, 32'd2, 1'b0, 12'h0, 12'h300);
        wait_result("t5");
        build_exp(32'd1, 32'd7, 32'd2, 1'b0, 12'h0, 12'h300, PT, 1'b0);
        compare_trace("t5");
        check("t5_polls", count_cmd(7'd9), PT);
        check("t5_err", res_err, 1'b1);
        check("t5_data", res_data, 32'd0);
        accept("t5");

        // 6: reset during LOAD_INP, then a fresh run
        done_at = 1; acc_val = 32'h0BAD_F00D;
        launch(32'd2, 32'd128, 32'd0, 1'b1, 12'h0F8, 12'hFF8);
        wait_cyc = 0;
        while (cfu_cmd != 7'd1 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("t6_reached_load_inp", cfu_cmd, 7'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cmd", cfu_cmd, NOP);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_rd_en", mem_rd_en, 1'b0);
        repeat (2) @(negedge clk);
        check("t6_rst_cmd_hold", cfu_cmd, NOP);
        check("t6_rst_inp1", cfu_inp1, 32'd0);
        rst_n = 1'b1;
        launch(32'd2, 32'd128, 32'd0, 1'b1, 12'h0F8, 12'hFF8);
        wait_result("t6");
        build_exp(32'd2, 32'd128, 32'd0, 1'b1, 12'h0F8, 12'hFF8, 1, 1'b1);
        compare_trace("t6");
        check("t6_data", res_data, 32'h0BAD_F00D);
        accept("t6");

        // 7: host stalls 10 cycles with start pulses, then start during the handshake
        acc_val = 32'hCAFE_F00D;
        launch(32'd1, 32'd0, 32'd0, 1'b0, 12'h0, 12'h400);
        wait_result("t7");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            depth = 32'd1; start = (i % 3 == 0);
            @(negedge clk);
            check($sformatf("t7_valid%0d", i), res_valid, 1'b1);
            check($sformatf("t7_data%0d", i), res_data, 32'hCAFE_F00D);
            check($sformatf("t7_cmd%0d", i), cfu_cmd, NOP);
        end
        @(posedge clk); #1;
        start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b0;
        check("t7_valid_drop", res_valid, 1'b0);
        check("t7_busy_drop", busy, 1'b0);
        @(posedge clk); #1;
        check("t7_start_ignored_busy", busy, 1'b0);
        check("t7_start_ignored_cmd", cfu_cmd, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
